hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Parametrised hazard controller for the 5-stage RV32I pipeline, successor to the combinational hazard unit. Resolves RAW data hazards by ALU-operand forwarding from the memory (M) and store/writeback (S) stages. Inserts load-use stalls and flushes on taken branches. Adds a sequential tracker that holds the pipeline while a multi-cycle execute operation (mul/div) occupies the execute (E) stage, plus a saturating stall-cycle counter for performance measurement.

## Interface
Parameters:
- ADDR_WIDTH, 5, register address width
- NUM_SRC, 2, number of source operands checked per instruction
- MC_LATENCY, 4, cycles a multi-cycle op occupies E; legal range 2..16
- CNT_WIDTH, 32, stall-counter width

Ports:
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  synchronous, active-high reset
- rsD_i  in  NUM_SRC x ADDR_WIDTH  source register addresses in decode (D)
- rsE_i  in  NUM_SRC x ADDR_WIDTH  source register addresses in E
- rdE_i  in  ADDR_WIDTH  destination register in E
- rdM_i  in  ADDR_WIDTH  destination register in M
- rdS_i  in  ADDR_WIDTH  destination register in S
- reg_wrM_i  in  1  register write enable in M
- reg_wrS_i  in  1  register write enable in S
- result_srcE_i  in  1  instruction in E is a load
- pc_srcE_i  in  1  taken branch/jump resolved in E
- mc_startE_i  in  1  instruction in E is a multi-cycle op
- forward_E_o  out  NUM_SRC x 2  per-operand forward select: 00 register file, 01 S stage, 10 M stage
- stallPC_o  out  1  hold PC
- stallFtoD_o  out  1  hold F/D register
- flushFtoD_o  out  1  clear F/D register
- stallDtoE_o  out  1  hold D/E register
- flushDtoE_o  out  1  clear D/E register
- flushEtoM_o  out  1  insert bubble into E/M register
- mc_done_o  out  1  last E cycle of a multi-cycle op
- stall_cnt_o  out  CNT_WIDTH  saturating count of PC-stall cycles

## Operation
- Forwarding, evaluated independently for each operand i:
  - If rsE_i[i] != 0, rsE_i[i] == rdM_i and reg_wrM_i: select 10.
  - Otherwise, if rsE_i[i] != 0, rsE_i[i] == rdS_i and reg_wrS_i: select 01.
  - Otherwise: select 00.
  - M has priority over S.
  - Address x0 never forwards.
- Load-use: result_srcE_i, rdE_i != 0 and rdE_i equal to any rsD_i[i] -> stallPC_o, stallFtoD_o and flushDtoE_o all asserted for that cycle.
- Branch: pc_srcE_i -> flushFtoD_o and flushDtoE_o. A branch suppresses any load-use stall in the same cycle.
- Multi-cycle tracker FSM, states IDLE and BUSY, with down-counter cnt:
  - IDLE with mc_startE_i: assert stall; go to BUSY with cnt = MC_LATENCY-2.
  - BUSY with cnt != 0: assert stall; cnt decrements.
  - BUSY with cnt == 0: no stall; mc_done_o = 1; go to IDLE.
  - mc_startE_i is ignored in BUSY, because the op is held in E.
  - Net effect: exactly MC_LATENCY-1 stall cycles, then one release cycle.
- Multi-cycle stall asserts stallPC_o, stallFtoD_o, stallDtoE_o and flushEtoM_o. Flush outputs to F/D and D/E are deasserted.
- Priority, highest first: rst_i, multi-cycle stall, branch flush, load-use stall.
- pc_srcE_i and result_srcE_i are ignored while the multi-cycle stall is asserted.
- stall_cnt_o increments by 1 in each cycle where stallPC_o = 1. It saturates at all-ones.

## Timing
- Forward selects and stall/flush outputs are combinational from the inputs and the registered FSM state, with zero-cycle latency.
- The FSM, cnt and stall_cnt_o update on the rising clk_i edge.
- Reset values: state IDLE, cnt 0, stall_cnt_o 0, mc_done_o 0. With all inputs at 0, every output is 0.
- Reset asserted mid-BUSY: the FSM is in IDLE and the stall is released in the cycle after the reset edge. stall_cnt_o clears.
- mc_startE_i asserted in the release cycle (the next op already in E) is not accepted; it is re-evaluated in IDLE on the following cycle.

## Structure
- Package hazard_pkg:
  - fwd_sel_t enum: FWD_RF=2'b00, FWD_S=2'b01, FWD_M=2'b10
  - mc_state_t enum: MC_IDLE, MC_BUSY
- Sub-module hazard_mc_tracker holds the FSM, cnt and mc_done_o. It exposes mc_stall to the top level.
- Forwarding, load-use, priority logic and stall_cnt live in hazard_ctrl.

## Test plan
- rsE=(5,6), rdM=5 with reg_wrM=1, rdS=6 with reg_wrS=1 -> forward_E_o=(10,01). With rsE=(0,x) and rdM=0 -> operand 0 selects 00.
- Load in E with rdE=7, rsD=(3,7) -> stallPC, stallFtoD and flushDtoE = 1 for one cycle. Repeat with rdE=0 -> no stall.
- pc_srcE=1 and a load-use match in the same cycle -> flushFtoD=flushDtoE=1, stallPC=0.
- MC_LATENCY=4, mc_startE held high for 4 cycles -> stall in cycles 1-3, mc_done in cycle 4, stall_cnt_o=3.
- rst_i in the second BUSY cycle -> the next cycle has all outputs 0 and state IDLE.
- CNT_WIDTH=4 with 20 consecutive load-use stalls -> stall_cnt_o saturates at 15.

Source files
------------

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types for the RV32I pipeline hazard controller
package hazard_pkg;

   typedef enum logic [1:0] {
      FWD_RF = 2'b00,
      FWD_S  = 2'b01,
      FWD_M  = 2'b10
   } fwd_sel_t;

   typedef enum logic {
      MC_IDLE = 1'b0,
      MC_BUSY = 1'b1
   } mc_state_t;

endpackage

// File: rtl/hazard_mc_tracker.sv
// rtl/hazard_mc_tracker.sv - holds the pipeline while a multi-cycle op sits in E
module hazard_mc_tracker
   import hazard_pkg::*;
#(
   parameter int MC_LATENCY = 4
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic mc_start,
   output logic mc_stall,
   output logic mc_done
);

   localparam int CW = $clog2(MC_LATENCY);

   mc_state_t         state;
   logic [CW-1:0]     cnt;

   // Stall is raised in the very cycle the op is first seen in E.
   assign mc_stall = (state == MC_IDLE) ? mc_start : (cnt != '0);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state   <= MC_IDLE;
         cnt     <= '0;
         mc_done <= 1'b0;
      end else begin
         case (state)
            MC_IDLE: begin
               if (mc_start) begin
                  state   <= MC_BUSY;
                  cnt     <= CW'(MC_LATENCY - 2);
                  mc_done <= (MC_LATENCY == 2);
               end else begin
                  mc_done <= 1'b0;
               end
            end
            MC_BUSY: begin
               // mc_done is precomputed so it lands on the cnt == 0 release cycle
               if (cnt != '0) begin
                  cnt     <= cnt - 1'b1;
                  mc_done <= (cnt == CW'(1));
               end else begin
                  state   <= MC_IDLE;
                  mc_done <= 1'b0;
               end
            end
            default: begin
               state   <= MC_IDLE;
               cnt     <= '0;
               mc_done <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - forwarding, load-use stall, branch flush and multi-cycle hold
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int ADDR_WIDTH = 5,
   parameter int NUM_SRC    = 2,
   parameter int MC_LATENCY = 4,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                                 clk_i,
   input  logic                                 rst_i,
   input  logic [NUM_SRC-1:0][ADDR_WIDTH-1:0]   rsD_i,
   input  logic [NUM_SRC-1:0][ADDR_WIDTH-1:0]   rsE_i,
   input  logic [ADDR_WIDTH-1:0]                rdE_i,
   input  logic [ADDR_WIDTH-1:0]                rdM_i,
   input  logic [ADDR_WIDTH-1:0]                rdS_i,
   input  logic                                 reg_wrM_i,
   input  logic                                 reg_wrS_i,
   input  logic                                 result_srcE_i,
   input  logic                                 pc_srcE_i,
   input  logic                                 mc_startE_i,
   output logic [NUM_SRC-1:0][1:0]              forward_E_o,
   output logic                                 stallPC_o,
   output logic                                 stallFtoD_o,
   output logic                                 flushFtoD_o,
   output logic                                 stallDtoE_o,
   output logic                                 flushDtoE_o,
   output logic                                 flushEtoM_o,
   output logic                                 mc_done_o,
   output logic [CNT_WIDTH-1:0]                 stall_cnt_o
);

   logic mc_stall;
   logic load_use;

   hazard_mc_tracker #(
      .MC_LATENCY (MC_LATENCY)
   ) u_mc_tracker (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .mc_start (mc_startE_i),
      .mc_stall (mc_stall),
      .mc_done  (mc_done_o)
   );

   // M wins over S because it holds the younger write to the same register.
   always_comb begin
      for (int i = 0; i < NUM_SRC; i++) begin
         forward_E_o[i] = FWD_RF;
         if (rsE_i[i] != '0 && rsE_i[i] == rdM_i && reg_wrM_i)
            forward_E_o[i] = FWD_M;
         else if (rsE_i[i] != '0 && rsE_i[i] == rdS_i && reg_wrS_i)
            forward_E_o[i] = FWD_S;
      end
   end

   always_comb begin
      load_use = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (result_srcE_i && rdE_i != '0 && rdE_i == rsD_i[i])
            load_use = 1'b1;
      end
   end

   always_comb begin
      stallPC_o   = 1'b0;
      stallFtoD_o = 1'b0;
      flushFtoD_o = 1'b0;
      stallDtoE_o = 1'b0;
      flushDtoE_o = 1'b0;
      flushEtoM_o = 1'b0;
      if (mc_stall) begin
         stallPC_o   = 1'b1;
         stallFtoD_o = 1'b1;
         stallDtoE_o = 1'b1;
         flushEtoM_o = 1'b1;
      end else if (pc_srcE_i) begin
         flushFtoD_o = 1'b1;
         flushDtoE_o = 1'b1;
      end else if (load_use) begin
         stallPC_o   = 1'b1;
         stallFtoD_o = 1'b1;
         flushDtoE_o = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i)
         stall_cnt_o <= '0;
      else if (stallPC_o && stall_cnt_o != '1)
         stall_cnt_o <= stall_cnt_o + 1'b1;
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed checks of hazard_ctrl forwarding, stalls, flushes and counter
module tb_hazard_ctrl;

   logic            clk = 1'b0;
   logic            rst;
   logic [1:0][4:0] rsD, rsE;
   logic [4:0]      rdE, rdM, rdS;
   logic            reg_wrM, reg_wrS, result_srcE, pc_srcE, mc_startE;
   logic [1:0][1:0] forward_E;
   logic            stallPC, stallFtoD, flushFtoD, stallDtoE, flushDtoE, flushEtoM, mc_done;
   logic [3:0]      stall_cnt;
   logic [5:0]      ctl;

   int pass_cnt  = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   hazard_ctrl #(
      .ADDR_WIDTH (5),
      .NUM_SRC    (2),
      .MC_LATENCY (4),
      .CNT_WIDTH  (4)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .rsD_i         (rsD),
      .rsE_i         (rsE),
      .rdE_i         (rdE),
      .rdM_i         (rdM),
      .rdS_i         (rdS),
      .reg_wrM_i     (reg_wrM),
      .reg_wrS_i     (reg_wrS),
      .result_srcE_i (result_srcE),
      .pc_srcE_i     (pc_srcE),
      .mc_startE_i   (mc_startE),
      .forward_E_o   (forward_E),
      .stallPC_o     (stallPC),
      .stallFtoD_o   (stallFtoD),
      .flushFtoD_o   (flushFtoD),
      .stallDtoE_o   (stallDtoE),
      .flushDtoE_o   (flushDtoE),
      .flushEtoM_o   (flushEtoM),
      .mc_done_o     (mc_done),
      .stall_cnt_o   (stall_cnt)
   );

   // {stallPC, stallFtoD, flushFtoD, stallDtoE, flushDtoE, flushEtoM}
   assign ctl = {stallPC, stallFtoD, flushFtoD, stallDtoE, flushDtoE, flushEtoM};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      if (obs === exp)
         pass_cnt++;
      else
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic clear_inputs();
      rsD = '0; rsE = '0; rdE = '0; rdM = '0; rdS = '0;
      reg_wrM = 1'b0; reg_wrS = 1'b0; result_srcE = 1'b0;
      pc_srcE = 1'b0; mc_startE = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic load_use_pattern();
      result_srcE = 1'b1; rdE = 5'd7; rsD[0] = 5'd3; rsD[1] = 5'd7;
   endtask

   initial begin
      do_reset();
      @(negedge clk);
      check("reset_fwd", 32'(forward_E), 32'h0);
      check("reset_ctl", 32'(ctl), 32'h0);
      check("reset_done", 32'(mc_done), 32'h0);
      check("reset_cnt", 32'(stall_cnt), 32'h0);

      // forwarding
      step();
      rsE[0] = 5'd5; rsE[1] = 5'd6; rdM = 5'd5; reg_wrM = 1'b1; rdS = 5'd6; reg_wrS = 1'b1;
      @(negedge clk);
      check("fwd_m_s", 32'(forward_E), 32'b0110);
      step();
      rsE[0] = 5'd9; rsE[1] = 5'd4; rdM = 5'd9; rdS = 5'd9;
      @(negedge clk);
      check("fwd_m_priority", 32'(forward_E), 32'b0010);
      step();
      rsE[1] = 5'd9; reg_wrM = 1'b0;
      @(negedge clk);
      check("fwd_m_no_wr", 32'(forward_E), 32'b0101);
      step();
      rsE[0] = 5'd0; rsE[1] = 5'd3; rdM = 5'd0; reg_wrM = 1'b1; rdS = 5'd3;
      @(negedge clk);
      check("fwd_x0", 32'(forward_E), 32'b0100);

      // load-use
      step();
      clear_inputs();
      load_use_pattern();
      @(negedge clk);
      check("lu_stall", 32'(ctl), 32'b110010);
      step();
      check("lu_cnt", 32'(stall_cnt), 32'd1);
      rdE = 5'd0; rsD[0] = 5'd3; rsD[1] = 5'd0;
      @(negedge clk);
      check("lu_rd0", 32'(ctl), 32'b000000);

      // branch beats load-use
      step();
      load_use_pattern();
      pc_srcE = 1'b1;
      @(negedge clk);
      check("branch_lu", 32'(ctl), 32'b001010);
      step();
      check("branch_cnt", 32'(stall_cnt), 32'd1);

      // multi-cycle op, branch/load-use ignored while held
      do_reset();
      for (int c = 1; c <= 3; c++) begin
         mc_startE = 1'b1;
         load_use_pattern();
         pc_srcE = 1'b1;
         @(negedge clk);
         check($sformatf("mc_stall_c%0d", c), 32'(ctl), 32'b110101);
         check($sformatf("mc_done_c%0d", c), 32'(mc_done), 32'h0);
         step();
      end
      clear_inputs();
      mc_startE = 1'b1;
      @(negedge clk);
      check("mc_release_ctl", 32'(ctl), 32'b000000);
      check("mc_release_done", 32'(mc_done), 32'h1);
      step();
      @(negedge clk);
      check("mc_restart_ctl", 32'(ctl), 32'b110101);
      check("mc_restart_done", 32'(mc_done), 32'h0);
      check("mc_cnt", 32'(stall_cnt), 32'd3);
      step();
      mc_startE = 1'b0;
      @(negedge clk);
      check("mc_busy_hold", 32'(ctl), 32'b110101);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      @(negedge clk);
      check("rst_busy_ctl", 32'(ctl), 32'h0);
      check("rst_busy_done", 32'(mc_done), 32'h0);
      check("rst_busy_cnt", 32'(stall_cnt), 32'h0);
      check("rst_busy_fwd", 32'(forward_E), 32'h0);
      step();
      mc_startE = 1'b1;
      @(negedge clk);
      check("rst_idle_accept", 32'(ctl), 32'b110101);

      // counter saturation
      do_reset();
      load_use_pattern();
      for (int c = 1; c <= 20; c++) begin
         step();
         if (c == 14) check("sat_14", 32'(stall_cnt), 32'd14);
         if (c == 15) check("sat_15", 32'(stall_cnt), 32'd15);
      end
      check("sat_20", 32'(stall_cnt), 32'd15);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
